// File: rtl/char_scroller_pkg.sv
// Shared character codes, 7-segment patterns and sizing helper for the
// character scroller.
package char_scroller_pkg;

    localparam logic [1:0] CHAR_H = 2'b00;
    localparam logic [1:0] CHAR_E = 2'b01;
    localparam logic [1:0] CHAR_L = 2'b10;
    localparam logic [1:0] CHAR_O = 2'b11;

    // Active-low segments, bit6=g .. bit0=a
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Never returns less than 1 so a 2-digit build still gets a 1-bit POS.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/char_seg7.sv
// One digit decoder: 2-bit character code plus valid flag to active-low
// 7-segment pattern; an empty slot shows blank.
module char_seg7
    import char_scroller_pkg::*;
(
    input  logic [1:0] code,
    input  logic       valid,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (valid) begin
            case (code)
                CHAR_H:  seg = SEG_H;
                CHAR_E:  seg = SEG_E;
                CHAR_L:  seg = SEG_L;
                default: seg = SEG_O;
            endcase
        end
    end

endmodule

// File: rtl/char_scroller.sv
// Loads selected characters into a digit shift register and, while RUN is
// high, rotates the stored word across NUM_DIGITS 7-segment displays.
module char_scroller
    import char_scroller_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 25000000,
    parameter int CNT_W      = 25,
    parameter int POS_W      = clog2(NUM_DIGITS)
) (
    input  logic                    CLOCK_50,
    input  logic                    RST,
    input  logic [1:0]              CHAR,
    input  logic                    LOAD,
    input  logic                    RUN,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [POS_W-1:0]        POS,
    output logic                    TICK
);

    logic [NUM_DIGITS-1:0][1:0] digit;
    logic [NUM_DIGITS-1:0]      valid;
    logic [CNT_W-1:0]           cnt;
    logic                       load_q;
    logic                       load_pulse;
    logic                       wrap;

    assign load_pulse = LOAD & ~load_q;
    assign wrap       = RUN && (cnt == CNT_W'(TICK_DIV - 1));

    // TICK is registered so it lines up with the rotated contents on HEX.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            load_q <= 1'b0;
            cnt    <= '0;
            TICK   <= 1'b0;
        end else begin
            load_q <= LOAD;
            TICK   <= wrap;
            if (!RUN || wrap)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

    // A load on the wrap cycle wins and swallows that step's rotation.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            digit <= '0;
            valid <= '0;
            POS   <= '0;
        end else if (load_pulse) begin
            digit <= {digit[NUM_DIGITS-2:0], CHAR};
            valid <= {valid[NUM_DIGITS-2:0], 1'b1};
        end else if (wrap) begin
            digit <= {digit[NUM_DIGITS-2:0], digit[NUM_DIGITS-1]};
            valid <= {valid[NUM_DIGITS-2:0], valid[NUM_DIGITS-1]};
            if (POS == POS_W'(NUM_DIGITS - 1))
                POS <= '0;
            else
                POS <= POS + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        char_seg7 u_seg (
            .code  (digit[i]),
            .valid (valid[i]),
            .seg   (HEX[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_char_scroller.sv
// Directed bench for char_scroller with 4 digits and a 4-cycle rotation step.
module tb_char_scroller;

    localparam logic [6:0] H = 7'b0001001;
    localparam logic [6:0] E = 7'b0000110;
    localparam logic [6:0] L = 7'b1000111;
    localparam logic [6:0] O = 7'b1000000;
    localparam logic [6:0] B = 7'b1111111;

    logic        CLOCK_50;
    logic        RST;
    logic [1:0]  CHAR;
    logic        LOAD;
    logic        RUN;
    logic [27:0] HEX;
    logic [1:0]  POS;
    logic        TICK;

    int n_cmp;
    int n_bad;

    char_scroller #(
        .NUM_DIGITS (4),
        .TICK_DIV   (4),
        .CNT_W      (3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RST      (RST),
        .CHAR     (CHAR),
        .LOAD     (LOAD),
        .RUN      (RUN),
        .HEX      (HEX),
        .POS      (POS),
        .TICK     (TICK)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [27:0] word(input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic load_char(input logic [1:0] c);
        CHAR = c;
        LOAD = 1'b1;
        cyc(1);
        LOAD = 1'b0;
        cyc(1);
    endtask

    logic [27:0] rot_exp [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1; CHAR = 2'b00; LOAD = 1'b0; RUN = 1'b0;

        // 1. reset
        cyc(2);
        check("rst_hex", 32'(HEX), 32'(word(B, B, B, B)));
        check("rst_pos", 32'(POS), 32'd0);
        check("rst_tick", 32'(TICK), 32'd0);
        RST = 1'b0;
        cyc(1);
        check("post_rst_hex", 32'(HEX), 32'(word(B, B, B, B)));

        // 2. load H,E,L then L with LOAD held; CHAR changes mid-hold
        load_char(2'b00);
        check("load1", 32'(HEX), 32'(word(B, B, B, H)));
        load_char(2'b01);
        load_char(2'b10);
        CHAR = 2'b10;
        LOAD = 1'b1;
        cyc(1);
        check("load4", 32'(HEX), 32'(word(H, E, L, L)));
        CHAR = 2'b11;
        cyc(9);
        check("load_held", 32'(HEX), 32'(word(H, E, L, L)));
        LOAD = 1'b0;
        cyc(1);

        // 3. rotate full word
        rot_exp[0] = word(E, L, L, H);
        rot_exp[1] = word(L, L, H, E);
        rot_exp[2] = word(L, H, E, L);
        rot_exp[3] = word(H, E, L, L);
        RUN = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cyc(3);
            check("rot_pre_tick", 32'(TICK), 32'd0);
            cyc(1);
            check("rot_tick", 32'(TICK), 32'd1);
            check("rot_hex", 32'(HEX), 32'(rot_exp[t]));
            check("rot_pos", 32'(POS), 32'((t + 1) % 4));
        end
        RUN = 1'b0;
        cyc(6);
        check("hold_hex", 32'(HEX), 32'(word(H, E, L, L)));
        check("hold_tick", 32'(TICK), 32'd0);

        // 4. partial word: single O walks up the digits
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        load_char(2'b11);
        check("part_load", 32'(HEX), 32'(word(B, B, B, O)));
        rot_exp[0] = word(B, B, O, B);
        rot_exp[1] = word(B, O, B, B);
        rot_exp[2] = word(O, B, B, B);
        rot_exp[3] = word(B, B, B, O);
        RUN = 1'b1;
        for (int t = 0; t < 4; t++) begin
            cyc(4);
            check("part_hex", 32'(HEX), 32'(rot_exp[t]));
            check("part_pos", 32'(POS), 32'((t + 1) % 4));
        end
        RUN = 1'b0;
        cyc(1);

        // 5. load edge coincident with the wrap edge
        RUN = 1'b1;
        cyc(3);
        CHAR = 2'b01;
        LOAD = 1'b1;
        cyc(1);
        check("coll_tick", 32'(TICK), 32'd1);
        check("coll_hex", 32'(HEX), 32'(word(B, B, O, E)));
        check("coll_pos", 32'(POS), 32'd0);
        LOAD = 1'b0;

        // 6. reset mid-rotation at POS=2, RUN stays high
        cyc(8);
        check("mid_pos", 32'(POS), 32'd2);
        check("mid_hex", 32'(HEX), 32'(word(O, E, B, B)));
        cyc(2);
        RST = 1'b1;
        cyc(1);
        check("mid_rst_hex", 32'(HEX), 32'(word(B, B, B, B)));
        check("mid_rst_pos", 32'(POS), 32'd0);
        check("mid_rst_tick", 32'(TICK), 32'd0);
        RST = 1'b0;
        cyc(3);
        check("restart_pre", 32'(TICK), 32'd0);
        cyc(1);
        check("restart_tick", 32'(TICK), 32'd1);
        check("restart_pos", 32'(POS), 32'd1);
        RUN = 1'b0;
        cyc(1);

        // 7. overfill drops the oldest character
        load_char(2'b00);
        load_char(2'b01);
        load_char(2'b10);
        load_char(2'b11);
        load_char(2'b01);
        check("overfill", 32'(HEX), 32'(word(E, L, O, E)));
        check("overfill_pos", 32'(POS), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
